pattern_scheduler: RTL and testbench

PATTERN_SCHEDULER -- requirements
Module: pattern_scheduler

---
 rtl/synth_pkg.sv | 19 +
 rtl/sched_fifo.sv | 50 +++++
 rtl/pattern_scheduler.sv | 164 ++++++++++++++++
 tb/tb_pattern_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types for the pattern scheduler: FSM state encoding, default
// address width and the pattern-table entry layout.
package synth_pkg;

  localparam int unsigned ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_SWITCH
  } state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] start_a;
    logic [ADDR_W_DEF-1:0] end_a;
  } pat_entry_t;

endpackage

// File: rtl/sched_fifo.sv
// Two-entry index FIFO; a push while full is taken only alongside a pop.
module sched_fifo #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         w_do_pop;
  logic         w_do_push;

  assign w_do_pop  = pop && (r_cnt != 2'd0);
  assign w_do_push = push && ((r_cnt != 2'd2) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wp] <= din;
        r_wp        <= ~r_wp;
      end
      if (w_do_pop) r_rp <= ~r_rp;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign dout  = r_mem[r_rp];
  assign full  = (r_cnt == 2'd2);
  assign empty = (r_cnt == 2'd0);

endmodule

// File: rtl/pattern_scheduler.sv
// Pattern scheduler: drives beat_counter ranges from a pattern table and a
// two-deep request queue. Define PATTERN_LOOP_EN to replay the current pattern
// when the queue is empty at wrap; otherwise playback returns to idle.
module pattern_scheduler
  import synth_pkg::*;
#(
  parameter  int unsigned ADDR_W  = ADDR_W_DEF,
  parameter  int unsigned NUM_PAT = 4,
  localparam int unsigned PIDX_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [PIDX_W-1:0] cfg_idx,
  input  logic [ADDR_W-1:0] cfg_start,
  input  logic [ADDR_W-1:0] cfg_end,
  input  logic              play,
  input  logic              stop,
  input  logic              req_valid,
  input  logic [PIDX_W-1:0] req_idx,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] beat_addr,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] end_addr,
  output logic              bc_reset,
  output logic              playing,
  output logic [PIDX_W-1:0] cur_idx
);

  typedef struct packed {
    logic [ADDR_W-1:0] start_a;
    logic [ADDR_W-1:0] end_a;
  } entry_t;

  entry_t            r_tbl [NUM_PAT];
  state_t            r_state;
  state_t            w_next;
  logic [PIDX_W-1:0] r_cur;
  logic [PIDX_W-1:0] w_sel;
  logic [PIDX_W-1:0] w_head;
  logic [ADDR_W-1:0] r_start;
  logic [ADDR_W-1:0] r_end;
  logic [ADDR_W-1:0] r_beat_q;
  logic              r_hit;
  logic              r_hit_d;
  logic              r_armed;
  logic              w_end_evt;
  logic              w_wrap;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_load;

  sched_fifo #(.W(PIDX_W)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (req_idx),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // A full queue still accepts a request in a cycle that pops the head.
  assign req_ready = !w_full || w_pop;
  assign w_push    = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_PAT; i++) r_tbl[i] <= '0;
    end else if (cfg_we) begin
      r_tbl[cfg_idx] <= '{start_a: cfg_start, end_a: cfg_end};
    end
  end

  // End event: first registered match of beat_addr against end_addr. A
  // degenerate range never changes beat_addr, so it counts as wrapping at once.
  assign w_end_evt = r_hit && !r_hit_d;
  assign w_wrap    = (beat_addr != r_beat_q) || (r_start == r_end);

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_load = 1'b0;
    w_sel  = r_cur;
    case (r_state)
      ST_IDLE: begin
        if (play) begin
          w_load = 1'b1;
          w_next = ST_LOAD;
          if (!w_empty) begin
            w_pop = 1'b1;
            w_sel = w_head;
          end
        end
      end
      ST_LOAD: w_next = ST_PLAY;
      ST_PLAY: begin
        if ((r_armed || w_end_evt) && w_wrap) w_next = ST_SWITCH;
      end
      ST_SWITCH: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_sel  = w_head;
          w_load = 1'b1;
          w_next = ST_LOAD;
        end else begin
`ifdef PATTERN_LOOP_EN
          w_load = 1'b1;
          w_next = ST_LOAD;
`else
          w_next = ST_IDLE;
`endif
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (stop) begin
      w_next = ST_IDLE;
      w_pop  = 1'b0;
      w_load = 1'b0;
    end
  end

  // Range registers update on entry to LOAD so the new start is visible in LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cur    <= '0;
      r_start  <= '0;
      r_end    <= '0;
      r_beat_q <= '0;
      r_hit    <= 1'b0;
      r_hit_d  <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_beat_q <= beat_addr;
      if (w_load) begin
        r_cur   <= w_sel;
        r_start <= r_tbl[w_sel].start_a;
        r_end   <= r_tbl[w_sel].end_a;
      end
      if (r_state == ST_PLAY) begin
        r_hit   <= (beat_addr == r_end);
        r_hit_d <= r_hit;
        if (w_end_evt) r_armed <= 1'b1;
      end else begin
        r_hit   <= 1'b0;
        r_hit_d <= 1'b0;
        r_armed <= 1'b0;
      end
    end
  end

  assign start_addr = r_start;
  assign end_addr   = r_end;
  assign cur_idx    = r_cur;
  assign playing    = (r_state == ST_PLAY);
  assign bc_reset   = (r_state == ST_IDLE) || (r_state == ST_LOAD);

endmodule

// File: tb/tb_pattern_scheduler.sv
// Self-checking bench for pattern_scheduler; expectations follow PATTERN_LOOP_EN.
module tb_pattern_scheduler;
  import synth_pkg::*;

  localparam int ADDR_W  = 10;
  localparam int NUM_PAT = 4;

  logic              clk;
  logic              reset;
  logic              cfg_we;
  logic [1:0]        cfg_idx;
  logic [ADDR_W-1:0] cfg_start;
  logic [ADDR_W-1:0] cfg_end;
  logic              play;
  logic              stop;
  logic              req_valid;
  logic [1:0]        req_idx;
  logic              req_ready;
  logic [ADDR_W-1:0] beat_addr;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              bc_reset;
  logic              playing;
  logic [1:0]        cur_idx;

  int total = 0;
  int bad   = 0;

  // Reference model: table contents, pending request queue, active index.
  pat_entry_t mtbl [NUM_PAT];
  int         mq [$];
  int         mcur;
  logic [23:0] obs, want;

  pattern_scheduler #(.ADDR_W(ADDR_W), .NUM_PAT(NUM_PAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_start  (cfg_start),
    .cfg_end    (cfg_end),
    .play       (play),
    .stop       (stop),
    .req_valid  (req_valid),
    .req_idx    (req_idx),
    .req_ready  (req_ready),
    .beat_addr  (beat_addr),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .bc_reset   (bc_reset),
    .playing    (playing),
    .cur_idx    (cur_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int idx, input int s, input int e);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_start = 10'(s); cfg_end = 10'(e);
    tick();
    cfg_we = 1'b0;
    mtbl[idx] = '{start_a: 10'(s), end_a: 10'(e)};
  endtask

  task automatic model_reset();
    mq.delete();
    mcur = 0;
    for (int i = 0; i < NUM_PAT; i++) mtbl[i] = '0;
  endtask

  // Issues play from IDLE and checks the LOAD cycle against the model's choice.
  task automatic play_and_check(input string nm);
    int sel;
    play = 1'b1;
    tick();
    play = 1'b0;
    sel  = (mq.size() > 0) ? mq.pop_front() : mcur;
    mcur = sel;
    obs  = {start_addr, end_addr, cur_idx, playing, bc_reset};
    want = {mtbl[sel].start_a, mtbl[sel].end_a, 2'(sel), 1'b0, 1'b1};
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, obs, want);
    end
    beat_addr = mtbl[sel].start_a;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (3) tick();
    obs  = {start_addr, end_addr, cur_idx, playing, bc_reset};
    want = {10'd0, 10'd0, 2'd0, 1'b0, 1'b1};
    total++;
    if (obs !== want) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", obs, want); end
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    reset = 1'b1;
    tick();
    total++;
    if ({playing, bc_reset} !== 2'b01) begin
      bad++; $display("FAIL reset_idle got=%b exp=01", {playing, bc_reset});
    end
  endtask

  task automatic test_load_play();
    write_entry(1, 0, 8);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL lp_ready got=%b exp=1", req_ready); end
    req_valid = 1'b1; req_idx = 2'd1; tick(); req_valid = 1'b0;
    mq.push_back(1);
    play_and_check("lp_load");
    tick();
    obs  = {start_addr, end_addr, cur_idx, playing, bc_reset};
    want = {10'd0, 10'd8, 2'd1, 1'b1, 1'b0};
    total++;
    if (obs !== want) begin bad++; $display("FAIL lp_play got=%h exp=%h", obs, want); end
  endtask

  task automatic test_switch();
    int sel;
    write_entry(2, 16, 23);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL sw_ready got=%b exp=1", req_ready); end
    req_valid = 1'b1; req_idx = 2'd2; tick(); req_valid = 1'b0;
    mq.push_back(2);
    for (int v = 0; v <= 8; v++) begin beat_addr = 10'(v); tick(); end
    beat_addr = 10'd0;
    tick();
    total++;
    if (start_addr !== 10'd0) begin bad++; $display("FAIL sw_one_clk got=%0d exp=0", start_addr); end
    tick();
    sel  = mq.pop_front();
    mcur = sel;
    obs  = {start_addr, end_addr, cur_idx, playing, bc_reset};
    want = {mtbl[sel].start_a, mtbl[sel].end_a, 2'(sel), 1'b0, 1'b1};
    total++;
    if (obs !== want) begin bad++; $display("FAIL sw_two_clk got=%h exp=%h", obs, want); end
    beat_addr = mtbl[sel].start_a;
    tick();
  endtask

  task automatic test_empty_wrap();
    for (int v = 16; v <= 23; v++) begin beat_addr = 10'(v); tick(); end
    beat_addr = 10'd16;
    tick();
    tick();
    obs = {start_addr, end_addr, cur_idx, playing, bc_reset};
`ifdef PATTERN_LOOP_EN
    want = {10'd16, 10'd23, 2'(mcur), 1'b0, 1'b1};
    total++;
    if (obs !== want) begin bad++; $display("FAIL ew_replay got=%h exp=%h", obs, want); end
    tick();
    total++;
    if ({playing, bc_reset} !== 2'b10) begin
      bad++; $display("FAIL ew_replay_play got=%b exp=10", {playing, bc_reset});
    end
    stop = 1'b1; tick(); stop = 1'b0;
`else
    want = {10'd16, 10'd23, 2'(mcur), 1'b0, 1'b1};
    total++;
    if (obs !== want) begin bad++; $display("FAIL ew_idle got=%h exp=%h", obs, want); end
    tick();
`endif
    total++;
    if ({playing, bc_reset} !== 2'b01) begin
      bad++; $display("FAIL ew_final_idle got=%b exp=01", {playing, bc_reset});
    end
  endtask

  task automatic test_queue_full();
    int idxs [3];
    idxs[0] = 3; idxs[1] = 1; idxs[2] = 2;
    write_entry(3, $urandom_range(100, 200), 210);
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_idx = 2'(idxs[k]);
      #1;
      total++;
      if (req_ready !== (mq.size() < 2)) begin
        bad++; $display("FAIL qf_ready%0d got=%b exp=%b", k, req_ready, mq.size() < 2);
      end
      if (mq.size() < 2) mq.push_back(idxs[k]);
      tick();
    end
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      play_and_check($sformatf("qf_load%0d", k));
      stop = 1'b1; tick(); stop = 1'b0;
    end
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL qf_drained got=%b exp=1", req_ready); end
  endtask

  task automatic test_stop_end();
    int ids [2];
    ids[0] = 3; ids[1] = 0;
    mcur = 1;
    play_and_check("se_load");
    beat_addr = 10'd0;
    tick();
    req_valid = 1'b1; req_idx = 2'd2; tick(); req_valid = 1'b0;
    mq.push_back(2);
    for (int v = 1; v <= 8; v++) begin beat_addr = 10'(v); tick(); end
    beat_addr = 10'd0; stop = 1'b1;
    tick();
    stop = 1'b0;
    obs  = {start_addr, end_addr, cur_idx, playing, bc_reset};
    want = {10'd0, 10'd8, 2'd1, 1'b0, 1'b1};
    total++;
    if (obs !== want) begin bad++; $display("FAIL se_idle got=%h exp=%h", obs, want); end
    for (int k = 0; k < 2; k++) begin
      req_valid = 1'b1; req_idx = 2'(ids[k]);
      #1;
      total++;
      if (req_ready !== (mq.size() < 2)) begin
        bad++; $display("FAIL se_count%0d got=%b exp=%b", k, req_ready, mq.size() < 2);
      end
      if (mq.size() < 2) mq.push_back(ids[k]);
      tick();
    end
    req_valid = 1'b0;
    play_and_check("se_head_kept");
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_degenerate();
    bit seen = 0;
    bit back = 0;
    write_entry(3, 5, 5);
    play_and_check("dg_load");
    for (int n = 0; n < 12 && !back; n++) begin
      tick();
      if (playing === 1'b1) seen = 1;
      if (seen && bc_reset === 1'b1) back = 1;
    end
    total++;
    if (!back || cur_idx !== 2'd3) begin
      bad++; $display("FAIL dg_nolock got=%b/%0d exp=1/3", back, cur_idx);
    end
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_reset_midplay();
    req_valid = 1'b1; req_idx = 2'd1; tick(); req_valid = 1'b0;
    mq.push_back(1);
    play_and_check("rm_load");
    tick();
    total++;
    if (playing !== 1'b1) begin bad++; $display("FAIL rm_playing got=%b exp=1", playing); end
    #2 reset = 1'b0;
    #1;
    model_reset();
    obs  = {start_addr, end_addr, cur_idx, playing, bc_reset};
    want = {10'd0, 10'd0, 2'd0, 1'b0, 1'b1};
    total++;
    if (obs !== want || req_ready !== 1'b1) begin
      bad++; $display("FAIL rm_async got=%h/%b exp=%h/1", obs, req_ready, want);
    end
    tick(); tick();
    reset = 1'b1;
    tick();
    total++;
    if ({playing, bc_reset, cur_idx} !== 4'b0100) begin
      bad++; $display("FAIL rm_idle got=%b exp=0100", {playing, bc_reset, cur_idx});
    end
    req_valid = 1'b1; req_idx = 2'd1; tick(); req_valid = 1'b0;
    mq.push_back(1);
    play_and_check("rm_table_cleared");
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_random();
    int sel;
    bit done;
    for (int i = 0; i < NUM_PAT; i++) begin
      int s = $urandom_range(0, 900);
      write_entry(i, s, s + $urandom_range(1, 6));
    end
    for (int iter = 0; iter < 6; iter++) begin
      for (int k = $urandom_range(1, 2); k > 0; k--) begin
        req_valid = 1'b1; req_idx = 2'($urandom_range(0, 3));
        if (mq.size() < 2) mq.push_back(int'(req_idx));
        tick();
      end
      req_valid = 1'b0;
      play_and_check($sformatf("rnd_start%0d", iter));
      tick();
      done = 0;
      for (int p = 0; p < 8 && !done; p++) begin
        for (int v = mtbl[mcur].start_a; v <= mtbl[mcur].end_a; v++) begin
          beat_addr = 10'(v);
          if (mq.size() < 2 && $urandom_range(0, 2) == 0) begin
            req_valid = 1'b1; req_idx = 2'($urandom_range(0, 3));
            #1;
            total++;
            if (req_ready !== 1'b1) begin bad++; $display("FAIL rnd_push got=%b exp=1", req_ready); end
            mq.push_back(int'(req_idx));
          end
          tick();
          req_valid = 1'b0;
        end
        beat_addr = mtbl[mcur].start_a;
        tick();
        tick();
        obs = {start_addr, end_addr, cur_idx, playing, bc_reset};
        if (mq.size() > 0) begin
          sel = mq.pop_front();
          mcur = sel;
          want = {mtbl[sel].start_a, mtbl[sel].end_a, 2'(sel), 1'b0, 1'b1};
        end else begin
          want = {mtbl[mcur].start_a, mtbl[mcur].end_a, 2'(mcur), 1'b0, 1'b1};
          done = 1;
        end
        total++;
        if (obs !== want) begin bad++; $display("FAIL rnd_next%0d_%0d got=%h exp=%h", iter, p, obs, want); end
        beat_addr = mtbl[mcur].start_a;
        tick();
      end
      stop = 1'b1; tick(); stop = 1'b0;
      total++;
      if ({playing, bc_reset} !== 2'b01) begin
        bad++; $display("FAIL rnd_stop%0d got=%b exp=01", iter, {playing, bc_reset});
      end
    end
  endtask

  initial begin
    reset = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_start = '0; cfg_end = '0;
    play = 1'b0; stop = 1'b0; req_valid = 1'b0; req_idx = '0; beat_addr = '0;
    test_reset();
    test_load_play();
    test_switch();
    test_empty_wrap();
    test_queue_full();
    test_stop_end();
    test_degenerate();
    test_reset_midplay();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
